// File: rtl/fm_stream_checker.sv
// fm_stream_checker: drains DUT and expected FIFOs in lockstep, compares per channel within a tolerance
module fm_stream_checker #(
    parameter int DATA_WIDTH     = 32,
    parameter int NUM_CH         = 2,
    parameter int SAMPLE_COUNT   = 65535,
    parameter int TOLERANCE      = 0,
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int CNT_WIDTH      = 32
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         start,
    input  logic [NUM_CH*DATA_WIDTH-1:0] dut_dout,
    input  logic                         dut_empty,
    output logic                         dut_rd_en,
    input  logic [NUM_CH*DATA_WIDTH-1:0] exp_dout,
    input  logic                         exp_empty,
    output logic                         exp_rd_en,
    output logic                         busy,
    output logic                         done,
    output logic                         pass,
    output logic                         timeout,
    output logic [CNT_WIDTH-1:0]         error_count,
    output logic [CNT_WIDTH-1:0]         sample_count,
    output logic [CNT_WIDTH-1:0]         cycle_count,
    output logic                         first_err_valid,
    output logic [CNT_WIDTH-1:0]         first_err_index,
    output logic [NUM_CH-1:0]            first_err_ch_mask
);
    typedef enum logic [1:0] {IDLE, RUN, DONE, TMO} state_t;
    localparam logic [DATA_WIDTH:0] TOL = (DATA_WIDTH+1)'(TOLERANCE);
    state_t state, state_nx;
    logic go, pop, last, expire, any_fail;
    logic [NUM_CH-1:0] ch_fail;
    logic [CNT_WIDTH-1:0] idle_cnt;
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [DATA_WIDTH-1:0] a, b;
        logic [DATA_WIDTH:0] d, mag;
        assign a = dut_dout[c*DATA_WIDTH +: DATA_WIDTH];
        assign b = exp_dout[c*DATA_WIDTH +: DATA_WIDTH];
        assign d = {a[DATA_WIDTH-1], a} - {b[DATA_WIDTH-1], b};
        assign mag = d[DATA_WIDTH] ? -d : d;
        assign ch_fail[c] = mag > TOL;
    end
    assign any_fail = |ch_fail;
    assign go = start && state != RUN;
    assign pop = !reset && state == RUN && !dut_empty && !exp_empty;
    assign dut_rd_en = pop;
    assign exp_rd_en = pop;
    assign busy = state == RUN;
    assign last = pop && sample_count == CNT_WIDTH'(SAMPLE_COUNT - 1);
    // a pop on the same edge as watchdog expiry always wins
    assign expire = state == RUN && !pop && idle_cnt == CNT_WIDTH'(TIMEOUT_CYCLES - 1);
    always_comb begin
        state_nx = state;
        state_nx = go ? RUN : last ? DONE : expire ? TMO : state;
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            state             <= IDLE;
            done              <= 1'b0;
            pass              <= 1'b0;
            timeout           <= 1'b0;
            error_count       <= '0;
            sample_count      <= '0;
            cycle_count       <= '0;
            idle_cnt          <= '0;
            first_err_valid   <= 1'b0;
            first_err_index   <= '0;
            first_err_ch_mask <= '0;
        end else begin
            state <= state_nx;
            if (go) begin
                done              <= 1'b0;
                pass              <= 1'b0;
                timeout           <= 1'b0;
                error_count       <= '0;
                sample_count      <= '0;
                cycle_count       <= '0;
                idle_cnt          <= '0;
                first_err_valid   <= 1'b0;
                first_err_index   <= '0;
                first_err_ch_mask <= '0;
            end else if (state == RUN) begin
                cycle_count <= cycle_count + CNT_WIDTH'(cycle_count != '1);
                idle_cnt    <= pop ? '0 : idle_cnt + 1'b1;
                if (pop) begin
                    sample_count <= sample_count + 1'b1;
                    if (any_fail) begin
                        error_count <= error_count + CNT_WIDTH'(error_count != '1);
                        if (!first_err_valid) begin
                            first_err_valid   <= 1'b1;
                            first_err_index   <= sample_count;
                            first_err_ch_mask <= ch_fail;
                        end
                    end
                end
                if (last) begin
                    done <= 1'b1;
                    pass <= error_count == '0 && !any_fail;
                end
                if (expire) begin
                    done    <= 1'b1;
                    timeout <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_fm_stream_checker.sv
// tb_fm_stream_checker: table-driven runs plus throttle, watchdog, restart and reset sequences
module tb_fm_stream_checker;
    typedef struct {
        logic [3:0][63:0] d, e;
        int err, idx;
        logic [1:0] mask;
        logic ps, ps0;
    } vec_t;
    logic clock = 0, reset = 1, start = 0;
    logic [63:0] dut_dout = '0, exp_dout = '0;
    logic dut_empty = 1, exp_empty = 1;
    logic dut_rd_en, exp_rd_en, busy, done, pass, timeout, fev;
    logic [31:0] error_count, sample_count, cycle_count, fei;
    logic [1:0] fem;
    logic rd0_d, rd0_e, busy0, done0, pass0, tmo0, fev0;
    logic [31:0] ec0, sc0, cc0, fei0;
    logic [1:0] fem0;
    logic [63:0] dq[$], eq[$];
    bit throttle = 0, tog = 0, pend = 0;
    int checks = 0, errors = 0;
    vec_t v[5];

    fm_stream_checker #(.DATA_WIDTH(32), .NUM_CH(2), .SAMPLE_COUNT(4), .TOLERANCE(1),
                        .TIMEOUT_CYCLES(16), .CNT_WIDTH(32)) dut (
        .clock(clock), .reset(reset), .start(start),
        .dut_dout(dut_dout), .dut_empty(dut_empty), .dut_rd_en(dut_rd_en),
        .exp_dout(exp_dout), .exp_empty(exp_empty), .exp_rd_en(exp_rd_en),
        .busy(busy), .done(done), .pass(pass), .timeout(timeout),
        .error_count(error_count), .sample_count(sample_count), .cycle_count(cycle_count),
        .first_err_valid(fev), .first_err_index(fei), .first_err_ch_mask(fem));

    fm_stream_checker #(.DATA_WIDTH(32), .NUM_CH(2), .SAMPLE_COUNT(4), .TOLERANCE(0),
                        .TIMEOUT_CYCLES(16), .CNT_WIDTH(32)) dut0 (
        .clock(clock), .reset(reset), .start(start),
        .dut_dout(dut_dout), .dut_empty(dut_empty), .dut_rd_en(rd0_d),
        .exp_dout(exp_dout), .exp_empty(exp_empty), .exp_rd_en(rd0_e),
        .busy(busy0), .done(done0), .pass(pass0), .timeout(tmo0),
        .error_count(ec0), .sample_count(sc0), .cycle_count(cc0),
        .first_err_valid(fev0), .first_err_index(fei0), .first_err_ch_mask(fem0));

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // FIFO model: refresh heads at negedge, retire the head popped at the previous posedge
    initial forever begin
        @(negedge clock);
        if (pend) begin
            void'(dq.pop_front());
            void'(eq.pop_front());
        end
        tog = !tog;
        dut_empty = dq.size() == 0 || (throttle && tog);
        exp_empty = eq.size() == 0;
        dut_dout = dq.size() != 0 ? dq[0] : '0;
        exp_dout = eq.size() != 0 ? eq[0] : '0;
        #3;
        pend = dut_rd_en;
        if (dut_rd_en || exp_rd_en)
            chk("rd_en_gate", {60'd0, dut_rd_en, exp_rd_en, dut_empty, exp_empty}, 64'b1100);
    end

    task automatic load(input logic [3:0][63:0] d, input logic [3:0][63:0] e, input int nd);
        dq.delete();
        eq.delete();
        for (int i = 0; i < 4; i++) begin
            eq.push_back(e[i]);
            if (i < nd) dq.push_back(d[i]);
        end
    endtask

    task automatic pulse_start();
        @(negedge clock); #2;
        start = 1;
        tog = 1;
        @(negedge clock); #2;
        start = 0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!done && n < 60) begin
            @(negedge clock); #2;
            n++;
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_flags"}, {56'd0, busy, done, pass, timeout, fev, fem, dut_rd_en}, 64'd0);
        chk({tag, "_exp_rd"}, {63'd0, exp_rd_en}, 64'd0);
        chk({tag, "_err_cnt"}, {32'd0, error_count}, 64'd0);
        chk({tag, "_smp_cnt"}, {32'd0, sample_count}, 64'd0);
        chk({tag, "_cyc_cnt"}, {32'd0, cycle_count}, 64'd0);
        chk({tag, "_fe_idx"}, {32'd0, fei}, 64'd0);
    endtask

    initial begin
        int n;
        v[0] = '{{64'h7FFFFFFF_00000003, 64'h00000002_FFFFFFFE, 64'h00000000_00000001, 64'h80000000_80000000},
                 {64'h7FFFFFFF_00000003, 64'h00000002_FFFFFFFE, 64'h00000000_00000001, 64'h80000000_80000000},
                 0, 0, 2'b00, 1'b1, 1'b1};
        v[1] = '{{64'h00000040_00000005, 64'hFFFFFFFF_00000030, 64'h00000020_00000021, 64'h00000010_00000011},
                 {64'h00000040_00000004, 64'h00000001_00000030, 64'h00000020_00000021, 64'h00000010_00000011},
                 1, 2, 2'b10, 1'b0, 1'b0};
        v[2] = '{{64'h3, 64'h2, 64'h1, 64'h00000000_7FFFFFFF},
                 {64'h3, 64'h2, 64'h1, 64'h00000000_80000000},
                 1, 0, 2'b01, 1'b0, 1'b0};
        v[3] = '{{64'h3, 64'h5, 64'h00000100_00000100, 64'h7},
                 {64'h0, 64'h5, 64'h0, 64'h7},
                 2, 1, 2'b11, 1'b0, 1'b0};
        v[4] = '{{64'h9, 64'h8, 64'h80000000_7FFFFFFF, 64'h00000006_00000004},
                 {64'h9, 64'h8, 64'h80000001_7FFFFFFE, 64'h00000005_00000005},
                 0, 0, 2'b00, 1'b1, 1'b0};

        repeat (3) @(negedge clock);
        #2;
        check_zero("reset");
        reset = 0;

        for (int i = 0; i < 5; i++) begin
            load(v[i].d, v[i].e, 4);
            pulse_start();
            wait_done(n);
            chk($sformatf("v%0d_latency", i), n, 4);
            chk($sformatf("v%0d_status", i), {busy, done, timeout}, 3'b010);
            chk($sformatf("v%0d_pass", i), pass, v[i].ps);
            chk($sformatf("v%0d_pass_tol0", i), pass0, v[i].ps0);
            chk($sformatf("v%0d_err_cnt", i), error_count, v[i].err);
            chk($sformatf("v%0d_smp_cnt", i), sample_count, 4);
            chk($sformatf("v%0d_cyc_cnt", i), cycle_count, 4);
            chk($sformatf("v%0d_fe_valid", i), fev, v[i].err != 0);
            chk($sformatf("v%0d_fe_idx", i), fei, v[i].idx);
            chk($sformatf("v%0d_fe_mask", i), fem, v[i].mask);
        end

        throttle = 1;
        load(v[0].d, v[0].e, 4);
        pulse_start();
        wait_done(n);
        throttle = 0;
        chk("thr_status", {busy, done, timeout, pass}, 4'b0101);
        chk("thr_smp_cnt", sample_count, 4);
        chk("thr_cyc_cnt", cycle_count, 7);

        load(v[0].d, v[0].e, 3);
        pulse_start();
        wait_done(n);
        chk("wd_latency", n, 19);
        chk("wd_status", {busy, done, timeout, pass}, 4'b0110);
        chk("wd_smp_cnt", sample_count, 3);
        chk("wd_cyc_cnt", cycle_count, 19);
        chk("wd_err_cnt", error_count, 0);

        load(v[1].d, v[1].d, 4);
        pulse_start();
        @(negedge clock); #2;
        start = 1;
        @(negedge clock); #2;
        start = 0;
        wait_done(n);
        chk("midstart_status", {busy, done, timeout, pass}, 4'b0101);
        chk("midstart_smp_cnt", sample_count, 4);
        chk("midstart_cyc_cnt", cycle_count, 4);

        load(v[3].d, v[3].e, 4);
        pulse_start();
        @(negedge clock); #2;
        @(negedge clock); #2;
        chk("rstrun_smp_cnt", sample_count, 2);
        reset = 1;
        #1;
        chk("rstrun_rd_en", {dut_rd_en, exp_rd_en}, 2'b00);
        @(negedge clock); #2;
        check_zero("rstrun");
        chk("rstrun_fifo_left", dq.size(), 2);
        reset = 0;
        load(v[2].d, v[2].d, 4);
        pulse_start();
        wait_done(n);
        chk("rerun_latency", n, 4);
        chk("rerun_status", {busy, done, timeout, pass}, 4'b0101);
        chk("rerun_smp_cnt", sample_count, 4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end
endmodule
